// File: rtl/wr_ptr_full_gen.sv
// Write-side pointer and status generator for the asynchronous FIFO.
// Owns the binary write pointer, publishes a registered gray pointer to the
// read domain, and derives full / almost_full / level / overflow from the
// already-synchronized read gray pointer, all in the write clock domain.
module wr_ptr_full_gen #(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned AF_THRESH = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              clr_ovf,
  input  logic [ADDR_W:0]   rd_gray_sync,
  output logic              wr_accept,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W:0]   wr_gray,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_level,
  output logic              overflow
);

  localparam logic [ADDR_W:0] AfThresh = AF_THRESH[ADDR_W:0];

  logic [ADDR_W:0] wbin_q, wbin_d;
  logic [ADDR_W:0] wgray_q, wgray_d;
  logic [ADDR_W:0] level_q, level_d;
  logic [ADDR_W:0] rbin;
  logic [ADDR_W:0] full_cmp;
  logic            full_q, full_d;
  logic            af_q, af_d;
  logic            ovf_q, ovf_d;
  logic            accept;

  // Accept gating: never while full, never while reset is held.
  always_comb begin
    accept = wr_en & ~full_q & ~rst;
  end

  // Gray-to-binary of the synchronized read pointer (xor of all right shifts).
  always_comb begin
    rbin = rd_gray_sync;
    for (int unsigned k = 1; k <= ADDR_W; k++) begin
      rbin = rbin ^ (rd_gray_sync >> k);
    end
  end

  // Next pointer, gray image, level and flags, all computed from the
  // post-write pointer so full asserts on the edge taking the last slot.
  always_comb begin
    wbin_d   = wbin_q + {{ADDR_W{1'b0}}, accept};
    wgray_d  = wbin_d ^ (wbin_d >> 1);
    // Full when write is exactly one lap ahead: top two gray bits inverted.
    full_cmp = {~rd_gray_sync[ADDR_W -: 2], rd_gray_sync[ADDR_W-2:0]};
    full_d   = (wgray_d == full_cmp);
    level_d  = wbin_d - rbin;
    af_d     = (level_d >= AfThresh);
    // Set dominates clear when both happen in one cycle.
    ovf_d    = (ovf_q & ~clr_ovf) | (wr_en & full_q);
  end

  // State registers; wr_gray comes straight off wgray_q for crossing safety.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      level_q <= level_d;
      full_q  <= full_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
    end
  end

  // Output mapping.
  always_comb begin
    wr_accept   = accept;
    wr_addr     = wbin_q[ADDR_W-1:0];
    wr_gray     = wgray_q;
    full        = full_q;
    almost_full = af_q;
    wr_level    = level_q;
    overflow    = ovf_q;
  end

endmodule

// File: tb/tb_wr_ptr_full_gen.sv
// Bench for wr_ptr_full_gen: directed walk through the main scenarios followed
// by random traffic, all checked against an arithmetic FIFO-occupancy model.
module tb_wr_ptr_full_gen;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int PMOD  = 2 * DEPTH;
  localparam int AFT   = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic          clr_ovf;
  logic [AW:0]   rd_gray_sync;
  logic          wr_accept;
  logic [AW-1:0] wr_addr;
  logic [AW:0]   wr_gray;
  logic          full;
  logic          almost_full;
  logic [AW:0]   wr_level;
  logic          overflow;

  wr_ptr_full_gen #(.ADDR_W(AW), .AF_THRESH(AFT)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .clr_ovf      (clr_ovf),
    .rd_gray_sync (rd_gray_sync),
    .wr_accept    (wr_accept),
    .wr_addr      (wr_addr),
    .wr_gray      (wr_gray),
    .full         (full),
    .almost_full  (almost_full),
    .wr_level     (wr_level),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: pointers as plain counters modulo 2*DEPTH, occupancy by subtraction.
  int m_wbin = 0;
  int m_rbin = 0;
  bit m_full = 0;
  bit m_af   = 0;
  bit m_ovf  = 0;
  int m_lvl  = 0;
  logic [AW:0] prev_gray = '0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [AW:0] to_gray(input int b);
    logic [AW:0] v;
    v = b[AW:0];
    return v ^ (v >> 1);
  endfunction

  task automatic check_regs(input string tag);
    chk({tag, ".wr_gray"}, int'(wr_gray), int'(to_gray(m_wbin)));
    chk({tag, ".wr_addr"}, int'(wr_addr), m_wbin % DEPTH);
    chk({tag, ".full"}, int'(full), int'(m_full));
    chk({tag, ".almost_full"}, int'(almost_full), int'(m_af));
    chk({tag, ".wr_level"}, int'(wr_level), m_lvl);
    chk({tag, ".overflow"}, int'(overflow), int'(m_ovf));
    chk({tag, ".gray_step"}, int'($countones(wr_gray ^ prev_gray) <= 1), 1);
    prev_gray = wr_gray;
  endtask

  // One clock: drive at edge+1, check combinational outputs, advance model,
  // then check registered outputs one time unit after the next edge.
  task automatic cycle(input string tag, input bit we, input bit clr, input int rb);
    bit acc;
    wr_en        = we;
    clr_ovf      = clr;
    rd_gray_sync = to_gray(rb);
    #1;
    acc = we && !m_full;
    chk({tag, ".wr_accept"}, int'(wr_accept), int'(acc));
    chk({tag, ".addr_pre"}, int'(wr_addr), m_wbin % DEPTH);
    m_ovf  = (m_ovf && !clr) || (we && m_full);
    m_wbin = (m_wbin + int'(acc)) % PMOD;
    m_rbin = rb;
    m_lvl  = (m_wbin - m_rbin + PMOD) % PMOD;
    m_full = (m_lvl == DEPTH);
    m_af   = (m_lvl >= AFT);
    @(posedge clk);
    #1;
    check_regs(tag);
  endtask

  task automatic model_reset();
    m_wbin = 0; m_rbin = 0; m_full = 0; m_af = 0; m_ovf = 0; m_lvl = 0;
    prev_gray = '0;
  endtask

  initial begin
    int rb;
    rst = 1'b1; wr_en = 1'b0; clr_ovf = 1'b0; rd_gray_sync = '0;
    repeat (2) @(posedge clk);
    #1;
    check_regs("reset");
    chk("reset.wr_accept", int'(wr_accept), 0);
    rst = 1'b0;

    // Idle after reset release.
    repeat (10) cycle("idle", 1'b0, 1'b0, 0);

    // Fill from empty with the read pointer parked at zero.
    repeat (DEPTH) cycle("fill", 1'b1, 1'b0, 0);
    chk("fill.gray_end", int'(wr_gray), 5'b11000);
    chk("fill.full_end", int'(full), 1);

    // Overflow: set, set-beats-clear, then clear alone.
    cycle("ovf_set", 1'b1, 1'b0, 0);
    chk("ovf_set.flag", int'(overflow), 1);
    cycle("ovf_both", 1'b1, 1'b1, 0);
    chk("ovf_both.flag", int'(overflow), 1);
    cycle("ovf_clr", 1'b0, 1'b1, 0);
    chk("ovf_clr.flag", int'(overflow), 0);

    // Reader advances to 4: room opens, then one more write.
    cycle("rd4", 1'b0, 1'b0, 4);
    chk("rd4.level", int'(wr_level), 12);
    cycle("rd4_wr", 1'b1, 1'b0, 4);
    chk("rd4_wr.level", int'(wr_level), 13);
    chk("rd4_wr.addr", int'(wr_addr), 1);

    // Drain to level 8 one gray step at a time, then write through the wrap.
    for (int r = 5; r <= 9; r++) cycle("drain", 1'b0, 1'b0, r);
    while (m_wbin != 0) begin
      rb = (m_wbin + 1 - 8 + PMOD) % PMOD;
      cycle("wrap", 1'b1, 1'b0, rb);
      chk("wrap.level8", int'(wr_level), 8);
    end
    chk("wrap.gray0", int'(wr_gray), 0);

    // Random traffic with a well-behaved reader.
    for (int i = 0; i < 400; i++) begin
      rb = m_rbin;
      if (rb != m_wbin && ($urandom % 3 != 0)) rb = (rb + 1) % PMOD;
      cycle("rand", 1'($urandom % 4 != 0), 1'($urandom % 8 == 0), rb);
    end

    // Asynchronous reset in the middle of a burst, between edges.
    repeat (5) cycle("burst", 1'b1, 1'b0, m_rbin);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst.wr_accept", int'(wr_accept), 0);
    check_regs("arst");
    rd_gray_sync = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle("post_rst", 1'b1, 1'b0, 0);
    chk("post_rst.addr", int'(wr_addr), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
